// File: rtl/ifetch_stage.sv
// Instruction-fetch front end: owns the PC, drives a 1-cycle synchronous imem and hands
// {instr, pc, pc+4} to decode over valid/ready. IFETCH_PERF_EN adds fetch/stall counters.
module ifetch_stage #(
  parameter int unsigned IMEM_AW  = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               if_valid,
  input  logic               id_ready,
  output logic [31:0]        if_instr,
  output logic [31:0]        if_pc,
  output logic [31:0]        if_pc_plus4,
  output logic               halted
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  localparam logic [31:0] Syscall = 32'h0000_000C;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_valid_q, pend_valid_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pc4_q, pc4_d;
  logic        accept;
  logic        syscall_cap;

  assign accept      = !valid_q || id_ready;
  // A syscall is recognised only as it moves into the output registers.
  assign syscall_cap = (state_q == StRun) && !redirect_valid && accept && pend_valid_q &&
                       (imem_rdata == Syscall);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (syscall_cap) state_d = StHalt;
      StHalt:  state_d = StHalt;
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    halted = (state_q == StHalt);
    // While stalled or halted the pending address is re-presented so imem_rdata stays valid.
    if (state_q == StRun && accept) begin
      imem_addr = fetch_pc_q[IMEM_AW+1:2];
    end else begin
      imem_addr = pend_pc_q[IMEM_AW+1:2];
    end
  end

  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    pend_pc_d    = pend_pc_q;
    pend_valid_d = pend_valid_q;
    valid_d      = valid_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    pc4_d        = pc4_q;
    if (state_q == StRun) begin
      if (redirect_valid) begin
        valid_d      = 1'b0;
        pend_valid_d = 1'b0;
        fetch_pc_d   = redirect_pc & 32'hFFFF_FFFC;
      end else if (accept) begin
        valid_d = pend_valid_q;
        if (pend_valid_q) begin
          instr_d = imem_rdata;
          pc_d    = pend_pc_q;
          pc4_d   = pend_pc_q + 32'd4;
        end
        pend_pc_d    = fetch_pc_q;
        pend_valid_d = !syscall_cap;
        fetch_pc_d   = fetch_pc_q + 32'd4;
      end
    end else if (id_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q   <= RESET_PC;
      pend_pc_q    <= 32'h0;
      pend_valid_q <= 1'b0;
      valid_q      <= 1'b0;
      instr_q      <= 32'h0;
      pc_q         <= 32'h0;
      pc4_q        <= 32'h0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_valid_q <= pend_valid_d;
      valid_q      <= valid_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
    end
  end

  assign if_valid    = valid_q;
  assign if_instr    = instr_q;
  assign if_pc       = pc_q;
  assign if_pc_plus4 = pc4_q;

`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count_q, stall_count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count_q <= 32'h0;
      stall_count_q <= 32'h0;
    end else if (valid_q) begin
      if (id_ready) fetch_count_q <= fetch_count_q + 32'd1;
      else          stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Directed bench for ifetch_stage: startup, stall, redirects, syscall halt and async reset.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        halted;
`ifdef IFETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  logic [31:0] mem [1024];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= mem[imem_addr];

  ifetch_stage #(
    .IMEM_AW  (10),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .id_ready       (id_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4),
    .halted         (halted)
`ifdef IFETCH_PERF_EN
    ,
    .fetch_count    (fetch_count),
    .stall_count    (stall_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] instr);
    check({tag, ".valid"}, {31'b0, if_valid}, {31'b0, v});
    if (v) begin
      check({tag, ".pc"}, if_pc, pc);
      check({tag, ".pc4"}, if_pc_plus4, pc + 32'd4);
      check({tag, ".instr"}, if_instr, instr);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]    = 32'h2008_0005;
    mem[1]    = 32'h2009_0007;
    mem[2]    = 32'h0109_5020;
    mem[16]   = 32'h1234_5678;
    mem[1023] = 32'hAABB_CCDD;
    reset          = 1'b0;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    #2;
    check("rst.valid", {31'b0, if_valid}, 32'h0);
    check("rst.pc", if_pc, 32'h0);
    check("rst.pc4", if_pc_plus4, 32'h0);
    check("rst.instr", if_instr, 32'h0);
    check("rst.halted", {31'b0, halted}, 32'h0);
    check("rst.addr", {22'b0, imem_addr}, 32'h0);
    #5 reset = 1'b1;

    tick();  // edge 1
    check_out("e1", 1'b0, 32'h0, 32'h0);
    check("e1.addr", {22'b0, imem_addr}, 32'd1);
    tick();  // edge 2
    check_out("e2", 1'b1, 32'h0, 32'h2008_0005);
    tick();  // edge 3
    check_out("e3", 1'b1, 32'h4, 32'h2009_0007);

    // Stall three cycles while pc 4 is presented
    id_ready = 1'b0;
    #1 check("stall.addr0", {22'b0, imem_addr}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall", 1'b1, 32'h4, 32'h2009_0007);
      check("stall.addr", {22'b0, imem_addr}, 32'd2);
    end
    id_ready = 1'b1;
    tick();  // edge 7
    check_out("unstall", 1'b1, 32'h8, 32'h0109_5020);
    tick();  // edge 8
    check_out("e8", 1'b1, 32'hC, 32'h0);

    // Redirect during a stall drops the held instruction
    id_ready = 1'b0;
    tick();
    check_out("hold", 1'b1, 32'hC, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    check_out("rd1.e", 1'b0, 32'h0, 32'h0);
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    tick();
    check_out("rd1.e1", 1'b0, 32'h0, 32'h0);
    tick();
    check_out("rd1.e2", 1'b1, 32'h40, 32'h1234_5678);

    // Misaligned target is forced to word alignment
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    tick();
    redirect_valid = 1'b0;
    check_out("rd2.e", 1'b0, 32'h0, 32'h0);
    tick();
    check_out("rd2.e1", 1'b0, 32'h0, 32'h0);
    tick();
    check_out("rd2.e2", 1'b1, 32'h40, 32'h1234_5678);

    // Top of address space: index aliases to 1023, pc wraps to 0
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    tick();
    check_out("wrap.top", 1'b1, 32'hFFFF_FFFC, 32'hAABB_CCDD);
    check("wrap.pc4", if_pc_plus4, 32'h0);
    tick();
    check_out("wrap.zero", 1'b1, 32'h0, 32'h2008_0005);

    // Syscall at pc 0xC halts fetch
    mem[3] = 32'h0000_000C;
    tick();
    check_out("sc.pc4", 1'b1, 32'h4, 32'h2009_0007);
    tick();
    check_out("sc.pc8", 1'b1, 32'h8, 32'h0109_5020);
    check("sc.run", {31'b0, halted}, 32'h0);
    tick();
    check_out("sc.cap", 1'b1, 32'hC, 32'h0000_000C);
    check("sc.halted", {31'b0, halted}, 32'h1);
    id_ready = 1'b0;
    tick();
    check_out("sc.held", 1'b1, 32'hC, 32'h0000_000C);
    id_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    tick();
    check_out("sc.acc", 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt.valid", {31'b0, if_valid}, 32'h0);
      check("halt.halted", {31'b0, halted}, 32'h1);
      check("halt.addr", {22'b0, imem_addr}, 32'd4);
    end
    redirect_valid = 1'b0;

    // Asynchronous reset between edges
    #2 reset = 1'b0;
    #1;
    check("arst.valid", {31'b0, if_valid}, 32'h0);
    check("arst.pc", if_pc, 32'h0);
    check("arst.pc4", if_pc_plus4, 32'h0);
    check("arst.instr", if_instr, 32'h0);
    check("arst.halted", {31'b0, halted}, 32'h0);
    check("arst.addr", {22'b0, imem_addr}, 32'h0);
`ifdef IFETCH_PERF_EN
    check("arst.fcnt", fetch_count, 32'h0);
    check("arst.scnt", stall_count, 32'h0);
`endif
    #2 reset = 1'b1;
    tick();
    check_out("rs.e1", 1'b0, 32'h0, 32'h0);
    tick();
    check_out("rs.e2", 1'b1, 32'h0, 32'h2008_0005);
    tick();
    check_out("rs.e3", 1'b1, 32'h4, 32'h2009_0007);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
